fpu_arbiter: RTL
================

Name: fpu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fpu_top instance between N requesters.
- Accepts one operation per requester via a valid/ready handshake.
- Drives the FPU register bus in order: operand A write, operand B write, command write, result capture.
- Returns the result with the requester ID on a single valid/ready response channel.
- Sits between the processing clients and the memory-mapped FPU.

Parameters:
- N, 4, number of requesters (2..8).
- FPU_BASE, 13'h0600, FPU register base address. A at +0x0, B at +0x4, CMD at +0x8.
- IDW, $clog2(N), width of rsp_id.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester accept; one-hot or zero.
- req_op  in  2*N  opcode per requester, slice i = [2i+1:2i]. 1=add, 2=sub, 3=mul, 0=illegal.
- req_a  in  32*N  operand A per requester, slice i = [32i+31:32i].
- req_b  in  32*N  operand B per requester.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  32  result.
- rsp_err  out  1  set when the op was illegal.
- fpu_cs  out  1  FPU chip_select.
- fpu_addr  out  13  FPU register address.
- fpu_wdata  out  32  FPU data_in.
- fpu_rdata  in  32  FPU data_out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset state: FSM in IDLE; round-robin pointer = 0 (requester 0 has highest priority).
- Reset output values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, fpu_cs=0, fpu_addr=0, fpu_wdata=0, busy=0.
- FSM states: IDLE, WR_A, WR_B, WR_CMD, CAPT, RESP.
- IDLE:
  - Grant goes to the first requester with valid=1, searching from pointer upward with modulo-N wrap.
  - req_ready[grant]=1 combinationally in the same cycle.
  - On the accepting edge: latch op/a/b/id; pointer <= grant+1 mod N.
  - If op!=0, go to WR_A. If op==0, go to RESP with rsp_data=0, rsp_err=1, and no FPU access.
  - With no valid requests, stay in IDLE.
- WR_A: fpu_cs=1, fpu_addr=FPU_BASE+0, fpu_wdata=A. Next state WR_B.
- WR_B: fpu_cs=1, fpu_addr=FPU_BASE+4, fpu_wdata=B. Next state WR_CMD.
- WR_CMD: fpu_cs=1, fpu_addr=FPU_BASE+8, fpu_wdata={30'b0, op}. Next state CAPT.
- CAPT: fpu_cs=0. The FPU result is valid this cycle; register fpu_rdata into rsp_data, rsp_err=0. Next state RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data, rsp_err held stable.
  - Go to IDLE on the edge where rsp_ready=1; otherwise hold (back-pressure, no FPU activity).
- fpu_cs is 0 in IDLE, CAPT and RESP. fpu_addr and fpu_wdata drive 0 whenever fpu_cs=0.
- Outputs rsp_*, fpu_* and busy are registered or derived directly from state. req_ready is the only combinational output.
- Latency, legal op: accept at edge T, rsp_valid high from T+5.
  - With rsp_ready=1, back in IDLE at T+6; next accept at T+6.
  - Peak throughput: 1 op per 6 cycles.
- Latency, illegal op: rsp_valid at T+1.
- Fairness: after a grant to requester i, requester i has lowest priority. Each continuously-requesting client is served within N grants.
- Requesters must hold valid, op and operands stable until ready. Dropping valid before ready is legal; no grant is made in that case.
- Requests arriving during a transaction wait. Arbitration happens only in IDLE.
- The arbiter never issues back-to-back transactions without passing through IDLE.
- Reset mid-operation: immediate return to reset values. The in-flight op is dropped with no response. The FPU may hold partial operand writes; the next transaction rewrites all of them.

Test Plan:
- Single request, requester 0: op=1, A=5, B=7. FPU bus shows writes 0x600=5, 0x604=7, 0x608=1 on consecutive cycles; rsp_valid at T+5 with rsp_data=12, rsp_id=0, rsp_err=0.
- Round-robin with N=4, all four requesting continuously with op=3, A=i+2, B=10. Grants are 0,1,2,3,0. Results are 20, 30, 40, 50 with matching rsp_id.
- Back-pressure: hold rsp_ready=0 for 10 cycles with the response at RESP. rsp_valid, rsp_data and rsp_id stay stable; fpu_cs=0; req_ready=0 throughout; release completes the handshake.
- Illegal op=0 from requester 2 with A=9. No fpu_cs pulse; rsp_valid at T+1 with rsp_err=1, rsp_data=0, rsp_id=2; pointer advances to 3.
- Sub with wrap: op=2, A=3, B=5. rsp_data=32'hFFFF_FFFE.
- reset_n asserted during WR_B. All outputs at reset values asynchronously; no response after release; a new request from requester 1 is granted (pointer back to 0).

Source files
------------

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter and bus sequencer that shares one
// memory-mapped FPU between N requesters. Each granted operation is
// written to the FPU as operand A, operand B and command. The result is
// then captured and returned with the owner's ID on a single response
// channel.
module fpu_arbiter #(
  parameter int          N        = 4,
  parameter logic [12:0] FPU_BASE = 13'h0600,
  parameter int          IDW      = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [2*N-1:0]    req_op,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              fpu_cs,
  output logic [12:0]       fpu_addr,
  output logic [31:0]       fpu_wdata,
  input  logic [31:0]       fpu_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_A   = 3'd1,
    WR_B   = 3'd2,
    WR_CMD = 3'd3,
    CAPT   = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t         state, state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic           grant_found;
  logic [1:0]     grant_op;
  logic [31:0]    grant_a, grant_b;
  logic           accept;

  logic [1:0]     op_q;
  logic [31:0]    a_q, b_q;
  logic [IDW-1:0] id_q;
  logic [31:0]    data_q;
  logic           err_q;

  // Requester indices wrap modulo N, which need not be a power of two.
  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'(v % N);
  endfunction

  // Pick the first valid requester at or above the pointer, wrapping around.
  // NOTE: every signal driven here gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    for (int k = 0; k < N; k++) begin
      if (!grant_found && req_valid[wrap(int'(ptr) + k)]) begin
        grant_found = 1'b1;
        grant       = wrap(int'(ptr) + k);
      end
    end
  end

  assign grant_op = req_op[2*int'(grant) +: 2];
  assign grant_a  = req_a[32*int'(grant) +: 32];
  assign grant_b  = req_b[32*int'(grant) +: 32];
  assign accept   = (state == IDLE) && grant_found;

  // Accept strobe back to the winner; the only combinational output.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic: fixed write sequence, illegal ops skip the FPU.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_found) state_next = (grant_op != 2'd0) ? WR_A : RESP;
      WR_A:    state_next = WR_B;
      WR_B:    state_next = WR_CMD;
      WR_CMD:  state_next = CAPT;
      CAPT:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FPU bus outputs decoded from state; address and data are zero when idle.
  always_comb begin
    fpu_cs    = 1'b0;
    fpu_addr  = '0;
    fpu_wdata = '0;
    unique case (state)
      WR_A: begin
        fpu_cs    = 1'b1;
        fpu_addr  = FPU_BASE;
        fpu_wdata = a_q;
      end
      WR_B: begin
        fpu_cs    = 1'b1;
        fpu_addr  = FPU_BASE + 13'h4;
        fpu_wdata = b_q;
      end
      WR_CMD: begin
        fpu_cs    = 1'b1;
        fpu_addr  = FPU_BASE + 13'h8;
        fpu_wdata = {30'b0, op_q};
      end
      default: ;
    endcase
  end

  // Latch the granted request, advance the pointer, capture the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        ptr  <= wrap(int'(grant) + 1);
        op_q <= grant_op;
        a_q  <= grant_a;
        b_q  <= grant_b;
        id_q <= grant;
        if (grant_op == 2'd0) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end
      end
      if (state == CAPT) begin
        data_q <= fpu_rdata;
        err_q  <= 1'b0;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign busy      = (state != IDLE);

endmodule
